// File: rtl/adder_4b.sv
// Ripple-carry adder with a combinational sum/carry and a one-cycle registered copy.
// Optional macro ADDER_OVF_EN adds signed-overflow outputs ovf and ovf_q.
module adder_4b #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_q
`ifdef ADDER_OVF_EN
    ,
    output logic             ovf,
    output logic             ovf_q
`endif
);

    // c[i] is the carry into cell i; c[WIDTH] is the carry-out of the whole chain.
    logic [WIDTH:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]   = a[i] ^ m[i] ^ c[i];
        assign c[i+1]   = (a[i] & m[i]) | (c[i] & (a[i] ^ m[i]));
    end

    assign carry = c[WIDTH];

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values;
    // the async reset clears all flops so no X ever leaves the registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum;
            carry_q <= carry;
        end
    end

`ifdef ADDER_OVF_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign ovf = c[WIDTH] ^ c[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf;
        end
    end
`endif

endmodule

// File: tb/tb_adder_4b.sv
// Self-checking bench for adder_4b: exhaustive combinational sweep, boundaries,
// register latency, async reset/release and randomized traffic vs. an arithmetic model.
module tb_adder_4b;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
`ifdef ADDER_OVF_EN
    logic             ovf;
    logic             ovf_q;
`endif

    int vectors;
    int miscompares;

    adder_4b #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .m       (m),
        .sum     (sum),
        .carry   (carry),
        .sum_q   (sum_q),
        .carry_q (carry_q)
`ifdef ADDER_OVF_EN
        ,
        .ovf     (ovf),
        .ovf_q   (ovf_q)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic int exp_sum(input int x, input int y);
        return (x + y) % (1 << WIDTH);
    endfunction

    function automatic logic exp_carry(input int x, input int y);
        return (x + y) > ((1 << WIDTH) - 1);
    endfunction

    function automatic logic exp_ovf(input int x, input int y);
        int sx, sy, s;
        sx = (x >= (1 << (WIDTH - 1))) ? x - (1 << WIDTH) : x;
        sy = (y >= (1 << (WIDTH - 1))) ? y - (1 << WIDTH) : y;
        s  = sx + sy;
        return (s > (1 << (WIDTH - 1)) - 1) || (s < -(1 << (WIDTH - 1)));
    endfunction

    task automatic check_comb(input string name, input int x, input int y);
        vectors++;
        if (sum !== WIDTH'(exp_sum(x, y)) || carry !== exp_carry(x, y)) begin
            miscompares++;
            $display("FAIL %s: a=%0d m=%0d got sum=%0d carry=%b expected sum=%0d carry=%b",
                     name, x, y, sum, carry, exp_sum(x, y), exp_carry(x, y));
        end
    endtask

    task automatic check_reg(input string name, input int es, input logic ec);
        vectors++;
        if (sum_q !== WIDTH'(es) || carry_q !== ec) begin
            miscompares++;
            $display("FAIL %s: got sum_q=%0d carry_q=%b expected sum_q=%0d carry_q=%b",
                     name, sum_q, carry_q, es, ec);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a     = 4'd5;
        m     = 4'd6;
        #1;
        check_reg("reset_regs", 0, 1'b0);
        check_comb("reset_comb_valid", 5, 6);
        @(posedge clk);
        #1;
        check_reg("reset_held_over_edge", 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_exhaustive();
        for (int x = 0; x < (1 << WIDTH); x++) begin
            for (int y = 0; y < (1 << WIDTH); y++) begin
                a = WIDTH'(x);
                m = WIDTH'(y);
                #1;
                check_comb("exhaustive", x, y);
            end
        end
    endtask

    task automatic test_wrap();
        int cases [4][4] = '{'{0, 0, 0, 0}, '{15, 1, 0, 1}, '{15, 15, 14, 1}, '{8, 7, 15, 0}};
        for (int i = 0; i < 4; i++) begin
            a = WIDTH'(cases[i][0]);
            m = WIDTH'(cases[i][1]);
            #1;
            vectors++;
            if (sum !== WIDTH'(cases[i][2]) || carry !== cases[i][3][0]) begin
                miscompares++;
                $display("FAIL wrap_%0d: got sum=%0d carry=%b expected sum=%0d carry=%0d",
                         i, sum, carry, cases[i][2], cases[i][3]);
            end
        end
    endtask

    task automatic test_register();
        @(negedge clk);
        a = 4'd9;
        m = 4'd9;
        @(posedge clk);
        #1;
        check_reg("reg_load_9p9", 2, 1'b1);
        a = 4'd1;
        m = 4'd2;
        #1;
        check_reg("reg_hold_between_edges", 2, 1'b1);
        check_comb("reg_comb_follows", 1, 2);
        @(posedge clk);
        #1;
        check_reg("reg_next_edge", 3, 1'b0);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        a = 4'd3;
        m = 4'd4;
        @(posedge clk);
        #1;
        check_reg("pre_reset_load", 7, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reg("async_reset_immediate", 0, 1'b0);
        check_comb("async_reset_comb", 3, 4);
        @(posedge clk);
        #1;
        check_reg("async_reset_held", 0, 1'b0);
    endtask

    task automatic test_release();
        @(negedge clk);
        a = 4'd3;
        m = 4'd4;
        #1;
        rst_n = 1'b1;
        #1;
        check_reg("release_before_edge", 0, 1'b0);
        @(posedge clk);
        #1;
        check_reg("release_first_load", 7, 1'b0);
    endtask

    task automatic test_random();
        int x, y;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            x = int'($urandom_range(0, (1 << WIDTH) - 1));
            y = int'($urandom_range(0, (1 << WIDTH) - 1));
            a = WIDTH'(x);
            m = WIDTH'(y);
            #1;
            check_comb("random_comb", x, y);
            @(posedge clk);
            #1;
            check_reg("random_reg", exp_sum(x, y), exp_carry(x, y));
        end
    endtask

`ifdef ADDER_OVF_EN
    task automatic test_ovf();
        int pairs [3][2] = '{'{7, 1}, '{8, 8}, '{15, 1}};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = WIDTH'(pairs[i][0]);
            m = WIDTH'(pairs[i][1]);
            #1;
            vectors++;
            if (ovf !== exp_ovf(pairs[i][0], pairs[i][1])) begin
                miscompares++;
                $display("FAIL ovf_%0d: got ovf=%b expected %b", i, ovf,
                         exp_ovf(pairs[i][0], pairs[i][1]));
            end
            check_comb("ovf_comb", pairs[i][0], pairs[i][1]);
            @(posedge clk);
            #1;
            vectors++;
            if (ovf_q !== exp_ovf(pairs[i][0], pairs[i][1])) begin
                miscompares++;
                $display("FAIL ovf_q_%0d: got ovf_q=%b expected %b", i, ovf_q,
                         exp_ovf(pairs[i][0], pairs[i][1]));
            end
        end
        for (int i = 0; i < 100; i++) begin
            int x, y;
            @(negedge clk);
            x = int'($urandom_range(0, (1 << WIDTH) - 1));
            y = int'($urandom_range(0, (1 << WIDTH) - 1));
            a = WIDTH'(x);
            m = WIDTH'(y);
            #1;
            vectors++;
            if (ovf !== exp_ovf(x, y)) begin
                miscompares++;
                $display("FAIL ovf_random: a=%0d m=%0d got ovf=%b expected %b", x, y, ovf, exp_ovf(x, y));
            end
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_exhaustive();
        test_wrap();
        test_register();
        test_async_reset();
        test_release();
        test_random();
`ifdef ADDER_OVF_EN
        test_ovf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
